hash_stream_bridge: RTL and testbench

HASH_STREAM_BRIDGE -- requirements
Module: hash_stream_bridge

---
 rtl/hash_bridge_pkg.sv | 17 +
 rtl/hash_stream_bridge_word_packer.sv | 47 ++++
 rtl/hash_stream_bridge.sv | 150 +++++++++++++++
 tb/tb_hash_stream_bridge.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/hash_bridge_pkg.sv
// Shared state encodings and mode constants for the hash stream bridge.
// Imported by the bridge top level and its testbench.
package hash_bridge_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_TGT   = 3'd1;
  localparam state_t ST_HASH  = 3'd2;
  localparam state_t ST_CMP   = 3'd3;
  localparam state_t ST_WRITE = 3'd4;
  localparam state_t ST_ACK   = 3'd5;

  localparam logic MODE_READ = 1'b0;
  localparam logic MODE_CMP  = 1'b1;

endpackage

// File: rtl/hash_stream_bridge_word_packer.sv
// Shifts host beats MSB-first into a core word; word_vld pulses one cycle after the last beat.
// Holds word_dat stable until the next beat; clr drops a partial word and any pending pulse.
module word_packer #(
  parameter int BUS_W  = 8,
  parameter int WORD_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              beat_vld,
  input  logic [BUS_W-1:0]  beat_dat,
  input  logic              clr,
  output logic              word_vld,
  output logic [WORD_W-1:0] word_dat
);

  localparam int NB = WORD_W / BUS_W;
  localparam int CW = $clog2(NB) + 1;

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      word_vld <= 1'b0;
    end else if (clr) begin
      cnt      <= '0;
      word_vld <= 1'b0;
    end else begin
      word_vld <= 1'b0;
      if (beat_vld) begin
        if (cnt == CW'(NB - 1)) begin
          cnt      <= '0;
          word_vld <= 1'b1;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end
    end
  end

  // Data path carries no reset; only the count and strobe need a known value.
  always_ff @(posedge clk) begin
    if (beat_vld && !clr)
      word_dat <= (word_dat << BUS_W) | WORD_W'(beat_dat);
  end

endmodule

// File: rtl/hash_stream_bridge.sv
// Bridges a narrow host beat stream to a hash core: feeds words, then reads out or compares the digest.
// One host beat per request with a mandatory idle cycle between requests; host stalls by holding rdy low.
module hash_stream_bridge
  import hash_bridge_pkg::*;
#(
  parameter int BUS_W    = 8,
  parameter int WORD_W   = 32,
  parameter int DIGEST_W = 256
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                mode,
  input  logic                rdy,
  input  logic [BUS_W-1:0]    din,
  output logic                rq,
  output logic                done,
  output logic [BUS_W-1:0]    dout,
  output logic                hit,
  output logic                c_start,
  input  logic                c_rq,
  output logic                c_rdy,
  output logic [WORD_W-1:0]   c_data,
  input  logic                c_done,
  input  logic [DIGEST_W-1:0] c_hash
);

  localparam int NDB = DIGEST_W / BUS_W;
  localparam int CW  = $clog2(NDB) + 1;

  state_t              state;
  logic                mode_q;
  logic [CW-1:0]       cnt;
  logic [DIGEST_W-1:0] target;
  logic                xfer;
  logic                last_beat;
  logic                want_req;
  logic                pk_vld;
  logic                pk_clr;
  logic [BUS_W-1:0]    beat_sel;

  assign xfer      = rq & rdy;
  assign last_beat = (cnt == CW'(NDB - 1));
  assign pk_vld    = (state == ST_HASH) & xfer;
  assign pk_clr    = (state == ST_IDLE) | ((state == ST_HASH) & c_done);
  assign beat_sel  = BUS_W'(c_hash >> (DIGEST_W - BUS_W * (int'(cnt) + 1)));

  // Hashing only asks for data while the core wants it and no word is waiting to be taken.
  always_comb begin
    want_req = 1'b0;
    case (state)
      ST_TGT, ST_WRITE, ST_ACK: want_req = 1'b1;
      ST_HASH:                  want_req = c_rq & ~c_rdy & ~c_done;
      default:                  want_req = 1'b0;
    endcase
  end

  word_packer #(
    .BUS_W  (BUS_W),
    .WORD_W (WORD_W)
  ) u_packer (
    .clk      (clk),
    .rst_n    (rst_n),
    .beat_vld (pk_vld),
    .beat_dat (din),
    .clr      (pk_clr),
    .word_vld (c_rdy),
    .word_dat (c_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      mode_q  <= MODE_READ;
      cnt     <= '0;
      rq      <= 1'b0;
      done    <= 1'b0;
      hit     <= 1'b0;
      c_start <= 1'b0;
      dout    <= '0;
    end else begin
      c_start <= 1'b0;
      if (xfer) begin
        rq <= 1'b0;
      end else if (!rq && want_req) begin
        rq <= 1'b1;
        if (state == ST_WRITE)
          dout <= beat_sel;
      end

      case (state)
        ST_IDLE: begin
          if (start) begin
            mode_q  <= mode;
            c_start <= 1'b1;
            cnt     <= '0;
            state   <= (mode == MODE_CMP) ? ST_TGT : ST_HASH;
          end
        end
        ST_TGT: begin
          if (xfer) begin
            if (last_beat) begin
              cnt   <= '0;
              state <= ST_HASH;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end
        ST_HASH: begin
          if (c_done) begin
            done  <= 1'b1;
            rq    <= 1'b0;
            cnt   <= '0;
            state <= (mode_q == MODE_CMP) ? ST_CMP : ST_WRITE;
          end
        end
        ST_CMP: begin
          hit   <= (c_hash < target);
          state <= ST_ACK;
        end
        ST_WRITE: begin
          if (xfer) begin
            if (last_beat) begin
              cnt   <= '0;
              done  <= 1'b0;
              state <= ST_IDLE;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end
        ST_ACK: begin
          if (xfer) begin
            done  <= 1'b0;
            hit   <= 1'b0;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if ((state == ST_TGT) && xfer)
      target <= (target << BUS_W) | DIGEST_W'(din);
  end

endmodule

// File: tb/tb_hash_stream_bridge.sv
// Directed testbench for hash_stream_bridge with a host model and a stub hash core.
`timescale 1ns/1ps
module tb_hash_stream_bridge;
  import hash_bridge_pkg::*;

  logic         clk;
  logic         rst_n;
  logic         start, mode, rdy;
  logic [7:0]   din;
  logic         rq, done, hit;
  logic [7:0]   dout;
  logic         c_start, c_rq, c_rdy, c_done;
  logic [31:0]  c_data;
  logic [255:0] c_hash;

  logic         start16, mode16, rdy16;
  logic [15:0]  din16;
  logic         rq16, done16, hit16;
  logic [15:0]  dout16;
  logic         cs16, crq16, crdy16, cdone16;
  logic [31:0]  cdata16;
  logic [255:0] chash16;

  hash_stream_bridge dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .rdy(rdy), .din(din),
    .rq(rq), .done(done), .dout(dout), .hit(hit), .c_start(c_start), .c_rq(c_rq),
    .c_rdy(c_rdy), .c_data(c_data), .c_done(c_done), .c_hash(c_hash)
  );

  hash_stream_bridge #(.BUS_W(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .mode(mode16), .rdy(rdy16), .din(din16),
    .rq(rq16), .done(done16), .dout(dout16), .hit(hit16), .c_start(cs16), .c_rq(crq16),
    .c_rdy(crdy16), .c_data(cdata16), .c_done(cdone16), .c_hash(chash16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          vec, miscmp;
  logic [7:0]  host_beats [64];
  int          host_idx, hold_cnt;
  bit          noise;
  logic [7:0]  rd [64];
  int          rd_n;
  logic [31:0] cw [8];
  int          cw_n, core_cnt, core_words;
  bit          ack_seen;
  logic        ack_hit;

  function automatic logic [255:0] ramp();
    logic [255:0] r;
    r = '0;
    for (int k = 0; k < 32; k++) r = (r << 8) | 256'(k);
    return r;
  endfunction

  task automatic clear_model();
    host_idx = 0; hold_cnt = 0; noise = 0; rd_n = 0; cw_n = 0;
    core_cnt = 0; core_words = 2; ack_seen = 0; ack_hit = 1'b0;
    c_rq = 1'b0; c_done = 1'b0;
    for (int k = 0; k < 64; k++) host_beats[k] = 8'h00;
  endtask

  // One clock of host and stub-core behaviour, evaluated on the falling edge.
  task automatic cycle();
    @(negedge clk);
    if (c_start) begin core_cnt = 0; c_done = 1'b0; c_rq = 1'b1; end
    if (c_rdy) begin
      if (cw_n < 8) cw[cw_n] = c_data;
      cw_n++; core_cnt++;
      if (core_cnt >= core_words) begin c_rq = 1'b0; c_done = 1'b1; end
    end
    if (!rq) begin
      rdy = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      din = 8'($urandom);
    end else if (hold_cnt > 0) begin
      rdy = 1'b0; hold_cnt--;
    end else begin
      rdy = 1'b1;
      if (done) begin
        if (rd_n < 64) rd[rd_n] = dout;
        rd_n++; ack_seen = 1; ack_hit = hit;
      end else begin
        din = host_beats[host_idx % 64]; host_idx++;
      end
    end
  endtask

  task automatic launch(input logic m);
    start = 1'b1; mode = m;
    cycle();
    start = 1'b0; mode = ~m;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      start = 1'($urandom); mode = 1'($urandom); rdy = 1'($urandom); din = 8'($urandom);
      c_rq = 1'($urandom); c_done = 1'($urandom); c_hash = {8{$urandom}};
      #1;
      vec++;
      if ({rq, done, hit, c_start, c_rdy} !== 5'b0 || dout !== 8'h00 || dut.state !== ST_IDLE) begin
        miscmp++;
        $display("FAIL reset: rq/done/hit/c_start/c_rdy=%b dout=%h state=%0d, want 00000/00/%0d",
                 {rq, done, hit, c_start, c_rdy}, dout, dut.state, ST_IDLE);
      end
    end
    start = 0; mode = 0; rdy = 0; din = 0; c_rq = 0; c_done = 0; c_hash = '0;
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_mode0();
    clear_model();
    for (int k = 0; k < 8; k++) host_beats[k] = 8'(k + 1);
    c_hash = ramp();
    start = 1'b1; mode = MODE_READ;
    cycle();
    mode = MODE_CMP;
    cycle();
    vec++;
    if (c_start !== 1'b0) begin
      miscmp++; $display("FAIL start_ignored: c_start=%b, want 0", c_start);
    end
    start = 1'b0;
    for (int i = 0; i < 1000 && rd_n < 32; i++) cycle();
    vec++;
    if (cw_n !== 2) begin miscmp++; $display("FAIL word_pulses: got %0d, want 2", cw_n); end
    vec++;
    if (cw[0] !== 32'h01020304) begin miscmp++; $display("FAIL word0: got %h, want 01020304", cw[0]); end
    vec++;
    if (cw[1] !== 32'h05060708) begin miscmp++; $display("FAIL word1: got %h, want 05060708", cw[1]); end
    vec++;
    if (rd_n !== 32) begin miscmp++; $display("FAIL readout_count: got %0d, want 32", rd_n); end
    for (int k = 0; k < 32; k++) begin
      vec++;
      if (rd[k] !== 8'(k)) begin miscmp++; $display("FAIL readout_beat%0d: got %h, want %h", k, rd[k], 8'(k)); end
    end
    cycle();
    vec++;
    if (done !== 1'b0 || rq !== 1'b0 || dut.state !== ST_IDLE) begin
      miscmp++; $display("FAIL done_fall: done=%b rq=%b state=%0d, want 0 0 %0d", done, rq, dut.state, ST_IDLE);
    end
  endtask

  task automatic test_mode1();
    logic [255:0] tgt;
    logic [255:0] hashes [3];
    logic         exp_hit [3];
    tgt = 256'h1 << 248;
    hashes[0] = ramp(); hashes[1] = tgt; hashes[2] = tgt << 1;
    exp_hit[0] = 1'b1; exp_hit[1] = 1'b0; exp_hit[2] = 1'b0;
    for (int j = 0; j < 3; j++) begin
      clear_model();
      host_beats[0] = 8'h01;
      for (int k = 32; k < 40; k++) host_beats[k] = 8'(8'hA0 + k);
      c_hash = hashes[j];
      launch(MODE_CMP);
      for (int i = 0; i < 1000 && !ack_seen; i++) cycle();
      vec++;
      if (ack_seen !== 1'b1 || ack_hit !== exp_hit[j]) begin
        miscmp++; $display("FAIL hit_case%0d: seen=%b hit=%b, want 1 %b", j, ack_seen, ack_hit, exp_hit[j]);
      end
      vec++;
      if (host_idx !== 40) begin miscmp++; $display("FAIL cmp_beats%0d: got %0d, want 40", j, host_idx); end
      cycle();
      vec++;
      if (done !== 1'b0 || hit !== 1'b0) begin
        miscmp++; $display("FAIL ack_clear%0d: done=%b hit=%b, want 0 0", j, done, hit);
      end
    end
  endtask

  task automatic test_hold_reset();
    clear_model();
    for (int k = 0; k < 8; k++) host_beats[k] = 8'(k + 1);
    c_hash = ramp(); noise = 1; hold_cnt = 5;
    launch(MODE_READ);
    for (int i = 0; i < 100 && hold_cnt > 0; i++) cycle();
    cycle();
    vec++;
    if (rq !== 1'b1 || host_idx !== 1) begin
      miscmp++; $display("FAIL hold: rq=%b beats=%0d, want 1 1", rq, host_idx);
    end
    for (int i = 0; i < 1000 && rd_n < 10; i++) cycle();
    vec++;
    if (cw[0] !== 32'h01020304 || cw[1] !== 32'h05060708) begin
      miscmp++; $display("FAIL noisy_words: got %h %h, want 01020304 05060708", cw[0], cw[1]);
    end
    #1; rst_n = 1'b0; rdy = 1'b0; #1;
    vec++;
    if (rq !== 1'b0 || done !== 1'b0 || dut.state !== ST_IDLE) begin
      miscmp++; $display("FAIL mid_reset: rq=%b done=%b state=%0d, want 0 0 %0d", rq, done, dut.state, ST_IDLE);
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      vec++;
      if (c_start !== 1'b0 || c_rdy !== 1'b0 || rq !== 1'b0) begin
        miscmp++; $display("FAIL reset_strobes: c_start=%b c_rdy=%b rq=%b, want 0 0 0", c_start, c_rdy, rq);
      end
    end
    rst_n = 1'b1;
    clear_model();
    for (int k = 0; k < 8; k++) host_beats[k] = 8'(8'h11 * (k + 1));
    noise = 1;
    launch(MODE_READ);
    for (int i = 0; i < 1000 && rd_n < 32; i++) cycle();
    vec++;
    if (rd_n !== 32 || rd[0] !== 8'h00 || rd[31] !== 8'h1F || cw[0] !== 32'h11223344) begin
      miscmp++; $display("FAIL restart: beats=%0d first=%h last=%h word0=%h, want 32 00 1f 11223344",
                         rd_n, rd[0], rd[31], cw[0]);
    end
    cycle();
    vec++;
    if (done !== 1'b0) begin miscmp++; $display("FAIL restart_done: got %b, want 0", done); end
  endtask

  task automatic test_bus16();
    logic [15:0] b16 [2];
    logic [15:0] exp16;
    int idx, nrd, nw;
    idx = 0; nrd = 0; nw = 0;
    b16[0] = 16'h0102; b16[1] = 16'h0304;
    chash16 = ramp(); crq16 = 1'b0; cdone16 = 1'b0;
    start16 = 1'b1; mode16 = MODE_READ;
    @(negedge clk);
    start16 = 1'b0; crq16 = 1'b1;
    for (int i = 0; i < 500 && nrd < 16; i++) begin
      @(negedge clk);
      if (crdy16) begin
        nw++; vec++;
        if (cdata16 !== 32'h01020304) begin miscmp++; $display("FAIL bus16_word: got %h, want 01020304", cdata16); end
        crq16 = 1'b0; cdone16 = 1'b1;
      end
      if (rq16) begin
        rdy16 = 1'b1;
        if (done16) begin
          exp16 = {8'(2 * nrd), 8'(2 * nrd + 1)};
          vec++;
          if (dout16 !== exp16) begin miscmp++; $display("FAIL bus16_beat%0d: got %h, want %h", nrd, dout16, exp16); end
          nrd++;
        end else begin
          din16 = b16[idx % 2]; idx++;
        end
      end else begin
        rdy16 = 1'b0;
      end
    end
    @(negedge clk);
    rdy16 = 1'b0;
    vec++;
    if (nw !== 1 || nrd !== 16 || idx !== 2 || done16 !== 1'b0) begin
      miscmp++; $display("FAIL bus16_job: words=%0d beats=%0d in=%0d done=%b, want 1 16 2 0", nw, nrd, idx, done16);
    end
  endtask

  initial begin
    vec = 0; miscmp = 0;
    rst_n = 1'b0; start = 0; mode = 0; rdy = 0; din = 0;
    c_rq = 0; c_done = 0; c_hash = '0;
    start16 = 0; mode16 = 0; rdy16 = 0; din16 = 0; crq16 = 0; cdone16 = 0; chash16 = '0;
    clear_model();
    test_reset();
    test_mode0();
    test_mode1();
    test_hold_reset();
    test_bus16();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miscmp);
    $finish;
  end

endmodule
